// File: rtl/nand3_response_checker_pkg.sv
// Shared constants for the NAND3 response checker: FSM state encodings and
// truth tables of the gates used in the logic-gate exercise.
package nand3_response_checker_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Bit k of each table is the gate output for input pattern k ({a,b,c}).
  localparam logic [7:0] NAND3_TT = 8'h7F;
  localparam logic [7:0] AND3_TT  = 8'h80;
  localparam logic [7:0] NOR3_TT  = 8'h01;
  localparam logic [7:0] XOR3_TT  = 8'h96;

endpackage

// File: rtl/nand3_response_checker_settle_timer.sv
// Loadable down-counter that times how long each pattern is held before the
// gate output is sampled; zero_c flags the end of the settle window.
module nand3_response_checker_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero_c
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/nand3_response_checker.sv
// Sweeps every input pattern into the gate under test, samples its output after
// a settle window and scores it against EXPECT_TT.
// Optional macro NAND3_CHECK_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module nand3_response_checker
  import nand3_response_checker_pkg::*;
#(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [(2**N_IN)-1:0] EXPECT_TT = NAND3_TT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dut_y,
  output logic [N_IN-1:0]        stim,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_cnt,
  output logic [(2**N_IN)-1:0]   fail_vec
);

  localparam int unsigned NPAT  = 2**N_IN;
  localparam int unsigned CNT_W = N_IN + 1;

  logic [1:0]       state, state_d;
  logic [N_IN-1:0]  stim_d;
  logic             busy_d, done_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic [NPAT-1:0]  fail_vec_d;
  logic             tmr_load, tmr_dec, tmr_zero_c;
  logic             mismatch_c, last_c;

  nand3_response_checker_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .zero_c (tmr_zero_c)
  );

  assign mismatch_c = (dut_y != EXPECT_TT[stim]);
  assign last_c     = (stim == {N_IN{1'b1}});
  assign pass       = done & (err_cnt == '0);

  // Next-state and next-result logic; dut_y only matters in SAMPLE.
  always_comb begin
    state_d    = state;
    stim_d     = stim;
    busy_d     = busy;
    done_d     = done;
    err_cnt_d  = err_cnt;
    fail_vec_d = fail_vec;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          stim_d     = '0;
          err_cnt_d  = '0;
          fail_vec_d = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          tmr_load   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero_c) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch_c) begin
          err_cnt_d        = err_cnt + CNT_W'(1);
          fail_vec_d[stim] = 1'b1;
        end
`ifdef NAND3_CHECK_STOP_ON_FAIL_EN
        if (last_c || mismatch_c) begin
`else
        if (last_c) begin
`endif
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_SETTLE;
          stim_d   = stim + N_IN'(1);
          tmr_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      stim     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      state    <= state_d;
      stim     <= stim_d;
      busy     <= busy_d;
      done     <= done_d;
      err_cnt  <= err_cnt_d;
      fail_vec <= fail_vec_d;
    end
  end

endmodule
